fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Sequences the 16-bit instruction memory: owns the program counter, drives the memory address each cycle and captures the returned word into a small prefetch queue.
- Presents fetched instructions to decode with a valid/ready handshake.
- Handles branch/jump redirects from execute and stops fetching on the reserved HALT encoding.
- Sits between instruction memory (combinational read, 1024 x 16) and the decode stage.

Parameters:
- ADDR_W, 10, instruction address width; memory depth 2^ADDR_W words
- INSTR_W, 16, instruction width
- RESET_PC, 0, PC value after reset
- QDEPTH, 2, prefetch queue entries (power of two, >=2)
- HALT_WORD, 16'hFFFF, encoding that stops fetch

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run_i  in  1  fetch enable; level-sensitive
- imem_addr_o  out  ADDR_W  address to instruction memory; equals current PC
- imem_instr_i  in  INSTR_W  word returned combinationally for imem_addr_o in the same cycle
- instr_valid_o  out  1  queue head holds a valid instruction
- instr_data_o  out  INSTR_W  queue head instruction
- instr_pc_o  out  ADDR_W  address the queue head was fetched from
- instr_ready_i  in  1  decode accepts head; pop when valid & ready
- redirect_valid_i  in  1  one-cycle pulse: change PC and flush the queue
- redirect_pc_i  in  ADDR_W  new PC
- pc_o  out  ADDR_W  current fetch PC
- halted_o  out  1  controller is in HALT

Behaviour:
- Reset (asynchronous assert, synchronous deassert use): PC=RESET_PC, queue empty, state IDLE, instr_valid_o=0, instr_data_o=0, instr_pc_o=0, halted_o=0, imem_addr_o=RESET_PC.
- States:
  - IDLE: no fetch. run_i=1 -> FETCH.
  - FETCH: fetch allowed. run_i=0 -> IDLE; pushing HALT_WORD -> HALT.
  - HALT: no fetch, halted_o=1. Left only by redirect (-> FETCH if run_i=1, else IDLE) or by reset.
- Push condition: state==FETCH, and (queue not full, or a pop occurs this cycle), and no redirect.
  - On push: queue entry {PC, imem_instr_i} written; PC <= PC+1, modulo 2^ADDR_W (1023 wraps to 0, no flag).
- Pop: instr_valid_o & instr_ready_i removes the head. Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Outputs instr_data_o, instr_pc_o and instr_valid_o are driven from queue registers, never combinationally from imem_instr_i.
- Latency: first instruction is visible on instr_valid_o in the cycle after the first FETCH-state edge. With a continuously ready decode, throughput is one instruction per cycle.
- Head stability: instr_data_o and instr_pc_o hold steady while instr_valid_o=1 and instr_ready_i=0.
- Redirect has the highest priority:
  - Queue is flushed and PC <= redirect_pc_i.
  - Any push or pop in that cycle is discarded, and instr_valid_o=0 the next cycle.
  - First redirected instruction is valid two edges after the redirect pulse, provided run_i=1.
- HALT_WORD handling: the HALT word is itself pushed and delivered to decode. PC does not advance past it; pc_o holds the HALT word's address + 1. Instructions already queued still drain.
- run_i deasserted: fetch stops the next edge and the queue still drains. Reasserting resumes at the held PC with no refetch or skip.
- Full queue with no pop: PC holds and imem_addr_o is stable.
- Reset mid-operation: the queue is discarded immediately; outputs take reset values asynchronously.

Test Plan:
- Reset then run_i=1, ready=1; memory 0..5 = 0x2C06, 0x2406, 0x0083, 0x67FE, 0x5082, 0x4581 -> instr_valid_o rises 1 cycle after run; instructions delivered in order with instr_pc_o 0..5, one per cycle.
- ready=0 for 5 cycles after run -> queue fills to 2 entries, pc_o stops at 2, head holds 0x2C06/pc 0; release ready -> 0x2C06, 0x2406, 0x0083 back-to-back with no gap or duplicate.
- Redirect to 0x001 while head is pc 3 and the queue is full -> next cycle instr_valid_o=0; two edges later head = 0x2406/pc 1; no stale pc 3/4 ever accepted.
- memory[6]=0xFFFF -> 0xFFFF delivered with instr_pc_o=6; halted_o=1; pc_o=7; no further valid words. Redirect to 0 -> halted_o=0 and fetch restarts at 0.
- PC wrap: redirect to 1022 with memory[1022]=0x1111, [1023]=0x2222, [0]=0x2C06 -> delivered pcs 1022, 1023, 0 in sequence.
- Assert rst_n=0 mid-stream with ready toggling -> instr_valid_o=0 and pc_o=0 without waiting for a clock edge; after release, fetch restarts from pc 0.

Source files
------------

// File: rtl/fetch_controller.sv
// Fetch controller: owns the program counter, addresses a combinational
// instruction memory and buffers returned words in a small prefetch queue
// that feeds decode through a valid/ready handshake. Execute-stage redirects
// flush the queue and reload the PC; the HALT encoding stops fetching.
module fetch_controller #(
  parameter int                   ADDR_W    = 10,
  parameter int                   INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC  = {ADDR_W{1'b0}},
  parameter int                   QDEPTH    = 2,
  parameter logic [INSTR_W-1:0]   HALT_WORD = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_data_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  input  logic               instr_ready_i,
  input  logic               redirect_valid_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               halted_o
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0]  PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(QDEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;

  logic [INSTR_W-1:0] r_q_data [QDEPTH];
  logic [ADDR_W-1:0]  r_q_pc   [QDEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_halt_push;

  // Queue status and the push/pop qualifiers; a redirect cancels both.
  assign w_full        = (r_count == CNT_FULL);
  assign instr_valid_o = (r_count != CNT_ZERO);
  assign w_pop         = instr_valid_o & instr_ready_i & ~redirect_valid_i;
  assign w_push        = (r_state == ST_FETCH) & (~w_full | w_pop) & ~redirect_valid_i;
  assign w_halt_push   = w_push & (imem_instr_i == HALT_WORD);

  // Outputs come straight from state registers, never from the memory bus.
  assign imem_addr_o  = r_pc;
  assign pc_o         = r_pc;
  assign halted_o     = (r_state == ST_HALT);
  assign instr_data_o = r_q_data[r_rd_ptr];
  assign instr_pc_o   = r_q_pc[r_rd_ptr];

  // Next-state logic: redirect overrides everything, including HALT.
  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid_i) begin
      if (run_i) begin
        w_state_nxt = ST_FETCH;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run_i) begin
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (w_halt_push) begin
            w_state_nxt = ST_HALT;
          end else if (!run_i) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
        ST_HALT: begin
          w_state_nxt = ST_HALT;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and PC registers; the PC advances only when a word is captured,
  // so it wraps modulo the memory depth and rests just past a HALT word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid_i) begin
        r_pc <= redirect_pc_i;
      end else if (w_push) begin
        r_pc <= r_pc + PC_ONE;
      end else begin
        r_pc <= r_pc;
      end
    end
  end

  // Prefetch queue: circular buffer of {pc, instr}; redirect flushes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_data[i] <= {INSTR_W{1'b0}};
        r_q_pc[i]   <= {ADDR_W{1'b0}};
      end
      r_rd_ptr <= PTR_ZERO;
      r_wr_ptr <= PTR_ZERO;
      r_count  <= CNT_ZERO;
    end else if (redirect_valid_i) begin
      r_rd_ptr <= PTR_ZERO;
      r_wr_ptr <= PTR_ZERO;
      r_count  <= CNT_ZERO;
    end else begin
      if (w_push) begin
        r_q_data[r_wr_ptr] <= imem_instr_i;
        r_q_pc[r_wr_ptr]   <= r_pc;
        r_wr_ptr           <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller. A behavioural array
// acts as the combinational instruction memory; expected values are
// hand-derived constants per scenario.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [9:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        ivalid;
  logic [15:0] idata;
  logic [9:0]  ipc;
  logic        ready;
  logic        redir;
  logic [9:0]  redir_pc;
  logic [9:0]  pc;
  logic        halted;

  logic [15:0] mem [1024];
  logic [15:0] exp_d [6] = '{16'h2C06, 16'h2406, 16'h0083, 16'h67FE, 16'h5082, 16'h4581};

  int n_cmp = 0;
  int n_bad = 0;

  // 100 MHz-style clock
  always #5 clk = ~clk;

  // Combinational instruction memory
  assign imem_instr = mem[imem_addr];

  fetch_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .run_i            (run),
    .imem_addr_o      (imem_addr),
    .imem_instr_i     (imem_instr),
    .instr_valid_o    (ivalid),
    .instr_data_o     (idata),
    .instr_pc_o       (ipc),
    .instr_ready_i    (ready),
    .redirect_valid_i (redir),
    .redirect_pc_i    (redir_pc),
    .pc_o             (pc),
    .halted_o         (halted)
  );

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic init_mem;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0100 + 16'(i);
    for (int i = 0; i < 6; i++) mem[i] = exp_d[i];
    mem[6]    = 16'h1A2B;
    mem[1022] = 16'h1111;
    mem[1023] = 16'h2222;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; run = 1'b0; ready = 1'b0; redir = 1'b0; redir_pc = 10'd0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; run = 1'b0; ready = 1'b0; redir = 1'b0; redir_pc = 10'd0;
    #2;
    n_cmp++; if (ivalid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", ivalid); end
    n_cmp++; if (pc !== 10'd0) begin n_bad++; $display("FAIL reset_pc got %0d want 0", pc); end
    n_cmp++; if (imem_addr !== 10'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
    n_cmp++; if (idata !== 16'h0000) begin n_bad++; $display("FAIL reset_data got %h want 0000", idata); end
    n_cmp++; if (ipc !== 10'd0) begin n_bad++; $display("FAIL reset_ipc got %0d want 0", ipc); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got %0b want 0", halted); end
    tick;
    rst_n = 1'b1;
    tick;
    n_cmp++; if (ivalid !== 1'b0 || pc !== 10'd0) begin n_bad++; $display("FAIL idle_hold valid=%0b pc=%0d want 0/0", ivalid, pc); end
  endtask

  task automatic test_stream;
    do_reset;
    run = 1'b1; ready = 1'b1;
    tick;
    n_cmp++; if (ivalid !== 1'b0) begin n_bad++; $display("FAIL stream_first_edge valid got %0b want 0", ivalid); end
    n_cmp++; if (pc !== 10'd0) begin n_bad++; $display("FAIL stream_first_edge pc got %0d want 0", pc); end
    for (int k = 0; k < 6; k++) begin
      tick;
      n_cmp++; if (ivalid !== 1'b1) begin n_bad++; $display("FAIL stream_valid k=%0d got %0b want 1", k, ivalid); end
      n_cmp++; if (idata !== exp_d[k]) begin n_bad++; $display("FAIL stream_data k=%0d got %h want %h", k, idata, exp_d[k]); end
      n_cmp++; if (ipc !== 10'(k)) begin n_bad++; $display("FAIL stream_ipc k=%0d got %0d want %0d", k, ipc, k); end
      n_cmp++; if (pc !== 10'(k + 1)) begin n_bad++; $display("FAIL stream_pc k=%0d got %0d want %0d", k, pc, k + 1); end
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    run = 1'b1; ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick;
      if (c >= 1) begin
        n_cmp++; if (idata !== 16'h2C06 || ipc !== 10'd0) begin n_bad++; $display("FAIL bp_hold c=%0d got %h/%0d want 2c06/0", c, idata, ipc); end
      end
    end
    n_cmp++; if (ivalid !== 1'b1) begin n_bad++; $display("FAIL bp_valid got %0b want 1", ivalid); end
    n_cmp++; if (pc !== 10'd2) begin n_bad++; $display("FAIL bp_pc got %0d want 2", pc); end
    n_cmp++; if (imem_addr !== 10'd2) begin n_bad++; $display("FAIL bp_addr got %0d want 2", imem_addr); end
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (ivalid !== 1'b1 || idata !== exp_d[k] || ipc !== 10'(k)) begin
        n_bad++; $display("FAIL bp_drain k=%0d got v=%0b %h/%0d want 1 %h/%0d", k, ivalid, idata, ipc, exp_d[k], k);
      end
      tick;
    end
  endtask

  task automatic test_redirect;
    do_reset;
    run = 1'b1; ready = 1'b1;
    for (int c = 0; c < 5; c++) tick;
    n_cmp++; if (ipc !== 10'd3) begin n_bad++; $display("FAIL redir_pre_ipc got %0d want 3", ipc); end
    ready = 1'b0;
    tick;
    n_cmp++; if (pc !== 10'd5 || ipc !== 10'd3) begin n_bad++; $display("FAIL redir_full pc=%0d ipc=%0d want 5/3", pc, ipc); end
    redir = 1'b1; redir_pc = 10'd1; ready = 1'b1;
    tick;
    redir = 1'b0;
    n_cmp++; if (ivalid !== 1'b0) begin n_bad++; $display("FAIL redir_flush valid got %0b want 0", ivalid); end
    n_cmp++; if (pc !== 10'd1) begin n_bad++; $display("FAIL redir_pc got %0d want 1", pc); end
    tick;
    n_cmp++; if (ivalid !== 1'b1 || idata !== 16'h2406 || ipc !== 10'd1) begin
      n_bad++; $display("FAIL redir_first got v=%0b %h/%0d want 1 2406/1", ivalid, idata, ipc);
    end
    tick;
    n_cmp++; if (ivalid !== 1'b1 || idata !== 16'h0083 || ipc !== 10'd2) begin
      n_bad++; $display("FAIL redir_second got v=%0b %h/%0d want 1 0083/2", ivalid, idata, ipc);
    end
  endtask

  task automatic test_halt;
    do_reset;
    mem[6] = 16'hFFFF;
    run = 1'b1; ready = 1'b1;
    tick;
    for (int k = 0; k < 6; k++) tick;
    n_cmp++; if (halted !== 1'b0 || ipc !== 10'd5) begin n_bad++; $display("FAIL halt_pre halted=%0b ipc=%0d want 0/5", halted, ipc); end
    tick;
    n_cmp++; if (ivalid !== 1'b1 || idata !== 16'hFFFF || ipc !== 10'd6) begin
      n_bad++; $display("FAIL halt_word got v=%0b %h/%0d want 1 ffff/6", ivalid, idata, ipc);
    end
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_flag got %0b want 1", halted); end
    n_cmp++; if (pc !== 10'd7) begin n_bad++; $display("FAIL halt_pc got %0d want 7", pc); end
    for (int c = 0; c < 3; c++) begin
      tick;
      n_cmp++; if (ivalid !== 1'b0 || pc !== 10'd7 || halted !== 1'b1) begin
        n_bad++; $display("FAIL halt_stay c=%0d v=%0b pc=%0d h=%0b want 0/7/1", c, ivalid, pc, halted);
      end
    end
    redir = 1'b1; redir_pc = 10'd0;
    tick;
    redir = 1'b0;
    n_cmp++; if (halted !== 1'b0 || ivalid !== 1'b0 || pc !== 10'd0) begin
      n_bad++; $display("FAIL halt_exit h=%0b v=%0b pc=%0d want 0/0/0", halted, ivalid, pc);
    end
    tick;
    n_cmp++; if (ivalid !== 1'b1 || idata !== 16'h2C06 || ipc !== 10'd0) begin
      n_bad++; $display("FAIL halt_restart got v=%0b %h/%0d want 1 2c06/0", ivalid, idata, ipc);
    end
    mem[6] = 16'h1A2B;
  endtask

  task automatic test_wrap;
    do_reset;
    run = 1'b1; ready = 1'b1; redir = 1'b1; redir_pc = 10'd1022;
    tick;
    redir = 1'b0;
    n_cmp++; if (ivalid !== 1'b0 || pc !== 10'd1022) begin n_bad++; $display("FAIL wrap_redir v=%0b pc=%0d want 0/1022", ivalid, pc); end
    tick;
    n_cmp++; if (idata !== 16'h1111 || ipc !== 10'd1022) begin n_bad++; $display("FAIL wrap_1022 got %h/%0d want 1111/1022", idata, ipc); end
    tick;
    n_cmp++; if (idata !== 16'h2222 || ipc !== 10'd1023) begin n_bad++; $display("FAIL wrap_1023 got %h/%0d want 2222/1023", idata, ipc); end
    n_cmp++; if (pc !== 10'd0) begin n_bad++; $display("FAIL wrap_pc got %0d want 0", pc); end
    tick;
    n_cmp++; if (ivalid !== 1'b1 || idata !== 16'h2C06 || ipc !== 10'd0) begin
      n_bad++; $display("FAIL wrap_0 got v=%0b %h/%0d want 1 2c06/0", ivalid, idata, ipc);
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    run = 1'b1; ready = 1'b1;
    for (int c = 0; c < 5; c++) tick;
    ready = 1'b0;
    tick;
    ready = 1'b1;
    tick;
    n_cmp++; if (ivalid !== 1'b1 || ipc !== 10'd4) begin n_bad++; $display("FAIL arst_pre v=%0b ipc=%0d want 1/4", ivalid, ipc); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ivalid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got %0b want 0", ivalid); end
    n_cmp++; if (pc !== 10'd0 || imem_addr !== 10'd0) begin n_bad++; $display("FAIL arst_pc pc=%0d addr=%0d want 0/0", pc, imem_addr); end
    n_cmp++; if (idata !== 16'h0000 || ipc !== 10'd0) begin n_bad++; $display("FAIL arst_head got %h/%0d want 0000/0", idata, ipc); end
    tick;
    rst_n = 1'b1;
    tick;
    n_cmp++; if (ivalid !== 1'b0) begin n_bad++; $display("FAIL arst_first_edge valid got %0b want 0", ivalid); end
    tick;
    n_cmp++; if (ivalid !== 1'b1 || idata !== 16'h2C06 || ipc !== 10'd0) begin
      n_bad++; $display("FAIL arst_restart got v=%0b %h/%0d want 1 2c06/0", ivalid, idata, ipc);
    end
  endtask

  initial begin
    init_mem;
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect;
    test_halt;
    test_wrap;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
